// File: rtl/render_control_pkg.sv
// Shared constants and types for the sprite renderer: screen geometry,
// fixed object sizes, default colours and the render FSM states.
package render_control_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int PLAYER_WIDTH = 3;
  localparam int BULLET_WIDTH = 1;

  localparam logic [2:0] COLOUR_BLACK  = 3'b000;
  localparam logic [2:0] COLOUR_GREEN  = 3'b010;
  localparam logic [2:0] COLOUR_YELLOW = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  // Pixel coordinates arrive one bit wider than the screen so that a square
  // hanging off the right/bottom edge never wraps back onto low coordinates.
  function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
    return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/square_scanner.sv
// Walks a w x w square row-major (x fastest), one pixel per cycle.
// Pixel outputs are registered; 'done' flags, combinationally, that the
// pixel being scanned this cycle is the last one so the caller can chain
// the next square without a bubble.
module square_scanner (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [2:0] width,
  output logic [8:0] pix_x,
  output logic [7:0] pix_y,
  output logic       pix_valid,
  output logic       done
);

  logic       active;
  logic [2:0] cnt_x;
  logic [2:0] cnt_y;
  logic [7:0] bx;
  logic [6:0] by;
  logic [2:0] bw;
  logic [2:0] last_off;

  assign last_off = bw - 3'd1;
  assign done     = active && (cnt_x == last_off) && (cnt_y == last_off);

  // Scan counters and registered pixel output; a start may land on the
  // final pixel of the previous square and takes over on the next edge.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      active    <= 1'b0;
      cnt_x     <= 3'd0;
      cnt_y     <= 3'd0;
      bx        <= 8'd0;
      by        <= 7'd0;
      bw        <= 3'd0;
      pix_x     <= 9'd0;
      pix_y     <= 8'd0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= active;
      pix_x     <= {1'b0, bx} + 9'(cnt_x);
      pix_y     <= {1'b0, by} + 8'(cnt_y);
      if (start) begin
        active <= (width != 3'd0);
        cnt_x  <= 3'd0;
        cnt_y  <= 3'd0;
        bx     <= base_x;
        by     <= base_y;
        bw     <= width;
      end else if (active) begin
        if (cnt_x == last_off) begin
          cnt_x <= 3'd0;
          if (cnt_y == last_off) begin
            cnt_y  <= 3'd0;
            active <= 1'b0;
          end else begin
            cnt_y <= cnt_y + 3'd1;
          end
        end else begin
          cnt_x <= cnt_x + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/render_control.sv
// Sprite renderer: arbitrates pending redraw requests by fixed priority,
// erases each object's last-drawn square in the background colour, then
// draws it at its new position. Output pixels are pipelined two stages
// behind the scan counters (scanner register, then output register).
module render_control
  import render_control_pkg::*;
#(
  parameter int         NUM_ENEMY     = 4,
  parameter logic [2:0] BG_COLOUR     = COLOUR_BLACK,
  parameter logic [2:0] PLAYER_COLOUR = COLOUR_GREEN,
  parameter logic [2:0] BULLET_COLOUR = COLOUR_YELLOW
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   redraw_all,
  input  logic                   player_move,
  input  logic                   bullet_move,
  input  logic [7:0]             playerX,
  input  logic [6:0]             playerY,
  input  logic [7:0]             bulletX,
  input  logic [6:0]             bulletY,
  input  logic [NUM_ENEMY-1:0]   enemy_move,
  input  logic [8*NUM_ENEMY-1:0] enemyX,
  input  logic [7*NUM_ENEMY-1:0] enemyY,
  input  logic [3*NUM_ENEMY-1:0] enemy_width,
  input  logic [2:0]             enemy_color,
  output logic                   plot,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             colour,
  output logic                   busy
);

  localparam int NUM_OBJ = NUM_ENEMY + 2;
  localparam int IDX_W   = $clog2(NUM_OBJ);

  // Live object table: index 0 player, 1 bullet, 2.. enemies.
  logic [7:0]         obj_x [NUM_OBJ];
  logic [6:0]         obj_y [NUM_OBJ];
  logic [2:0]         obj_w [NUM_OBJ];
  logic [2:0]         obj_c [NUM_OBJ];
  logic [NUM_OBJ-1:0] obj_move;

  // Last-drawn record per object.
  logic [7:0] lst_x [NUM_OBJ];
  logic [6:0] lst_y [NUM_OBJ];
  logic [2:0] lst_w [NUM_OBJ];

  logic [NUM_OBJ-1:0] pending;
  logic [NUM_OBJ-1:0] pending_clr;
  logic               any_pending;
  logic [IDX_W-1:0]   sel_idx;
  logic               take;

  state_t state, state_next;

  // Snapshot of the object being serviced.
  logic [IDX_W-1:0] snap_idx;
  logic [7:0]       snap_x;
  logic [6:0]       snap_y;
  logic [2:0]       snap_w;
  logic [2:0]       snap_c;

  // Draw source: live inputs while still in IDLE, snapshot afterwards.
  logic [7:0]       draw_x;
  logic [6:0]       draw_y;
  logic [2:0]       draw_w;
  logic [IDX_W-1:0] commit_idx;
  logic             commit;

  logic       scan_start;
  logic [7:0] scan_bx;
  logic [6:0] scan_by;
  logic [2:0] scan_bw;
  logic [8:0] scan_x;
  logic [7:0] scan_y;
  logic       scan_valid;
  logic       scan_done;
  logic [2:0] cur_colour;
  logic [2:0] pipe_colour;

  // Flatten the per-port object description into indexable tables.
  always_comb begin
    obj_x[0]    = playerX;
    obj_y[0]    = playerY;
    obj_w[0]    = 3'(PLAYER_WIDTH);
    obj_c[0]    = PLAYER_COLOUR;
    obj_move[0] = player_move;
    obj_x[1]    = bulletX;
    obj_y[1]    = bulletY;
    obj_w[1]    = 3'(BULLET_WIDTH);
    obj_c[1]    = BULLET_COLOUR;
    obj_move[1] = bullet_move;
    for (int e = 0; e < NUM_ENEMY; e++) begin
      obj_x[e+2]    = enemyX[8*e +: 8];
      obj_y[e+2]    = enemyY[7*e +: 7];
      obj_w[e+2]    = enemy_width[3*e +: 3];
      obj_c[e+2]    = enemy_color;
      obj_move[e+2] = enemy_move[e];
    end
  end

  // Fixed-priority pick of the lowest pending index.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    sel_idx     = '0;
    any_pending = |pending;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  assign take        = (state == ST_IDLE) && any_pending;
  assign pending_clr = take ? (NUM_OBJ'(1) << sel_idx) : '0;
  assign draw_x      = (state == ST_IDLE) ? obj_x[sel_idx] : snap_x;
  assign draw_y      = (state == ST_IDLE) ? obj_y[sel_idx] : snap_y;
  assign draw_w      = (state == ST_IDLE) ? obj_w[sel_idx] : snap_w;
  assign commit_idx  = (state == ST_IDLE) ? sel_idx : snap_idx;
  assign busy        = (state != ST_IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // FSM next state; zero-width squares are skipped without spending a cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_pending) begin
          if (lst_w[sel_idx] != 3'd0) state_next = ST_ERASE;
          else if (draw_w != 3'd0)    state_next = ST_DRAW;
        end
      end
      ST_ERASE: if (scan_done) state_next = (snap_w != 3'd0) ? ST_DRAW : ST_IDLE;
      ST_DRAW:  if (scan_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: scanner launch, last-drawn commit and pixel colour.
  always_comb begin
    scan_start = (state_next != state) && (state_next != ST_IDLE);
    scan_bx    = draw_x;
    scan_by    = draw_y;
    scan_bw    = draw_w;
    if (state_next == ST_ERASE) begin
      scan_bx = lst_x[sel_idx];
      scan_by = lst_y[sel_idx];
      scan_bw = lst_w[sel_idx];
    end
    commit     = (state_next == ST_IDLE) && ((state != ST_IDLE) || any_pending);
    cur_colour = (state == ST_DRAW) ? snap_c : BG_COLOUR;
  end

  // Pending flags: a same-cycle set wins over the clear from arbitration.
  always_ff @(posedge clk) begin
    if (!resetn) pending <= '0;
    else         pending <= (pending & ~pending_clr) | obj_move | {NUM_OBJ{redraw_all}};
  end

  // Snapshot taken as the object leaves IDLE, including the enemy colour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      snap_idx <= '0;
      snap_x   <= 8'd0;
      snap_y   <= 7'd0;
      snap_w   <= 3'd0;
      snap_c   <= 3'd0;
    end else if (take) begin
      snap_idx <= sel_idx;
      snap_x   <= obj_x[sel_idx];
      snap_y   <= obj_y[sel_idx];
      snap_w   <= obj_w[sel_idx];
      snap_c   <= obj_c[sel_idx];
    end
  end

  // Last-drawn records, updated when an object's service completes.
  // NOTE: this small register file is reset on purpose: it is loaded from
  // the live inputs so the first erase after reset targets real pixels.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        lst_x[i] <= obj_x[i];
        lst_y[i] <= obj_y[i];
        lst_w[i] <= obj_w[i];
      end
    end else if (commit) begin
      lst_x[commit_idx] <= draw_x;
      lst_y[commit_idx] <= draw_y;
      lst_w[commit_idx] <= draw_w;
    end
  end

  square_scanner u_scanner (
    .clk       (clk),
    .resetn    (resetn),
    .start     (scan_start),
    .base_x    (scan_bx),
    .base_y    (scan_by),
    .width     (scan_bw),
    .pix_x     (scan_x),
    .pix_y     (scan_y),
    .pix_valid (scan_valid),
    .done      (scan_done)
  );

  // Output stage: colour travels alongside the scanner register, and
  // off-screen pixels keep their cycle but do not write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pipe_colour <= 3'd0;
      plot        <= 1'b0;
      vga_x       <= 8'd0;
      vga_y       <= 7'd0;
      colour      <= 3'd0;
    end else begin
      pipe_colour <= cur_colour;
      plot        <= scan_valid && on_screen(scan_x, scan_y);
      if (scan_valid) begin
        vga_x  <= scan_x[7:0];
        vga_y  <= scan_y[6:0];
        colour <= pipe_colour;
      end
    end
  end

endmodule

// File: tb/tb_render_control.sv
// Scoreboard bench for render_control: each redraw request is expanded by a
// square-level model into the expected pixel stream; a monitor compares every
// plotted pixel against that stream.
module tb_render_control;

  localparam int NE = 4;
  localparam int NO = NE + 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            redraw_all = 1'b0;
  logic            player_move = 1'b0;
  logic            bullet_move = 1'b0;
  logic [7:0]      playerX, bulletX;
  logic [6:0]      playerY, bulletY;
  logic [NE-1:0]   enemy_move = '0;
  logic [8*NE-1:0] enemyX;
  logic [7*NE-1:0] enemyY;
  logic [3*NE-1:0] enemy_width;
  logic [2:0]      enemy_color;
  logic            plot;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      colour;
  logic            busy;

  // Model state: current and last-drawn squares per object.
  int         c_x [NO], c_y [NO], c_w [NO];
  int         l_x [NO], l_y [NO], l_w [NO];
  logic [2:0] c_ecol;
  logic [17:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  render_control #(.NUM_ENEMY(NE)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .redraw_all  (redraw_all),
    .player_move (player_move),
    .bullet_move (bullet_move),
    .playerX     (playerX),
    .playerY     (playerY),
    .bulletX     (bulletX),
    .bulletY     (bulletY),
    .enemy_move  (enemy_move),
    .enemyX      (enemyX),
    .enemyY      (enemyY),
    .enemy_width (enemy_width),
    .enemy_color (enemy_color),
    .plot        (plot),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .colour      (colour),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Monitor: every plotted pixel must be the next expected one.
  always @(negedge clk) begin
    if (plot) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no plot",
                 vga_x, vga_y, colour);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({vga_x, vga_y, colour} == e) n_pass++;
        else $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                      vga_x, vga_y, colour, e[17:10], e[9:3], e[2:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_inputs();
    playerX = 8'(c_x[0]);
    playerY = 7'(c_y[0]);
    bulletX = 8'(c_x[1]);
    bulletY = 7'(c_y[1]);
    for (int e = 0; e < NE; e++) begin
      enemyX[8*e +: 8]      = 8'(c_x[e+2]);
      enemyY[7*e +: 7]      = 7'(c_y[e+2]);
      enemy_width[3*e +: 3] = 3'(c_w[e+2]);
    end
    enemy_color = c_ecol;
  endtask

  function automatic logic [2:0] obj_colour(input int i);
    if (i == 0) return 3'b010;
    if (i == 1) return 3'b110;
    return c_ecol;
  endfunction

  // One service: erase old square in black, draw new one, remember it.
  task automatic service(input int i);
    for (int dy = 0; dy < l_w[i]; dy++)
      for (int dx = 0; dx < l_w[i]; dx++)
        if (l_x[i] + dx < 160 && l_y[i] + dy < 120)
          exp_q.push_back({8'(l_x[i] + dx), 7'(l_y[i] + dy), 3'b000});
    for (int dy = 0; dy < c_w[i]; dy++)
      for (int dx = 0; dx < c_w[i]; dx++)
        if (c_x[i] + dx < 160 && c_y[i] + dy < 120)
          exp_q.push_back({8'(c_x[i] + dx), 7'(c_y[i] + dy), obj_colour(i)});
    l_x[i] = c_x[i];
    l_y[i] = c_y[i];
    l_w[i] = c_w[i];
  endtask

  task automatic pulse(input logic [NO-1:0] mask, input bit redraw);
    player_move = mask[0];
    bullet_move = mask[1];
    enemy_move  = mask[NO-1:2];
    redraw_all  = redraw;
    for (int i = 0; i < NO; i++) if (mask[i] || redraw) service(i);
    tick();
    player_move = 1'b0;
    bullet_move = 1'b0;
    enemy_move  = '0;
    redraw_all  = 1'b0;
  endtask

  task automatic observe(input int window, output int busy_cycles,
                         output int first_plot, output int drop);
    bit seen;
    busy_cycles = 0;
    first_plot  = -1;
    drop        = -1;
    seen        = 0;
    repeat (window) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        seen = 1;
      end else if (seen && drop < 0) begin
        drop = cyc;
      end
      if (plot && first_plot < 0) first_plot = cyc;
    end
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int quiet;
    quiet = 0;
    for (int n = 0; n < limit && quiet < 4; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_busy"}, int'(busy), 0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, fp, dr, t0;
    // Initial scene.
    c_x[0] = 79;  c_y[0] = 115; c_w[0] = 3;
    c_x[1] = 20;  c_y[1] = 20;  c_w[1] = 1;
    c_x[2] = 10;  c_y[2] = 10;  c_w[2] = 2;
    c_x[3] = 40;  c_y[3] = 50;  c_w[3] = 3;
    c_x[4] = 150; c_y[4] = 10;  c_w[4] = 4;
    c_x[5] = 100; c_y[5] = 100; c_w[5] = 1;
    c_ecol = 3'b101;
    apply_inputs();
    resetn = 1'b0;
    repeat (3) tick();
    check("reset_plot", int'(plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_vga_x", int'(vga_x), 0);
    check("reset_vga_y", int'(vga_y), 0);
    check("reset_colour", int'(colour), 0);
    for (int i = 0; i < NO; i++) begin
      l_x[i] = c_x[i]; l_y[i] = c_y[i]; l_w[i] = c_w[i];
    end
    resetn = 1'b1;
    tick();
    observe(10, bc, fp, dr);
    check("idle_busy_cycles", bc, 0);

    // Player step right: latency and service length.
    c_x[0] = 80;
    apply_inputs();
    tick();
    t0 = cyc;
    pulse(6'b000001, 0);
    observe(40, bc, fp, dr);
    check("player_first_plot_cycle", fp, t0 + 4);
    check("player_busy_cycles", bc, 18);
    check("player_busy_drop_cycle", dr, t0 + 20);
    wait_quiet("player", 200);

    // Player and enemy 0 together: strict index order.
    c_x[0] = 81;
    c_x[2] = 12;
    apply_inputs();
    tick();
    pulse(6'b000101, 0);
    wait_quiet("player_enemy0", 300);

    // Enemy 2 hanging off the right edge.
    c_x[4] = 158;
    apply_inputs();
    tick();
    pulse(6'b010000, 0);
    observe(60, bc, fp, dr);
    check("edge_busy_cycles", bc, 32);
    wait_quiet("edge", 200);

    // Enemy 0 grows, dies, then is pulsed again while dead.
    c_w[2] = 3;
    apply_inputs();
    tick();
    pulse(6'b000100, 0);
    wait_quiet("grow", 200);
    c_w[2] = 0;
    apply_inputs();
    tick();
    pulse(6'b000100, 0);
    observe(40, bc, fp, dr);
    check("dead_erase_busy_cycles", bc, 9);
    wait_quiet("dead_erase", 200);
    pulse(6'b000100, 0);
    observe(20, bc, fp, dr);
    check("dead_again_busy_cycles", bc, 0);
    wait_quiet("dead_again", 100);

    // Enemy colour change after snapshot must not affect the draw.
    c_x[5] = 102;
    apply_inputs();
    tick();
    pulse(6'b100000, 0);
    tick();
    c_ecol = 3'b011;
    apply_inputs();
    wait_quiet("colour_snapshot", 200);

    // Bullet re-pulsed during its own DRAW cycle.
    c_x[1] = 25;
    apply_inputs();
    tick();
    pulse(6'b000010, 0);
    tick();
    tick();
    pulse(6'b000010, 0);
    wait_quiet("bullet_repulse", 200);

    // Reset mid-erase, with redraw and a move pulse in the reset cycle.
    c_x[3] = 44;
    apply_inputs();
    tick();
    pulse(6'b001000, 0);
    tick();
    tick();
    tick();
    resetn      = 1'b0;
    redraw_all  = 1'b1;
    player_move = 1'b1;
    c_x[0]      = 85;
    apply_inputs();
    tick();
    exp_q.delete();
    check("midreset_plot", int'(plot), 0);
    check("midreset_busy", int'(busy), 0);
    for (int i = 0; i < NO; i++) begin
      l_x[i] = c_x[i]; l_y[i] = c_y[i]; l_w[i] = c_w[i];
    end
    resetn      = 1'b1;
    redraw_all  = 1'b0;
    player_move = 1'b0;
    observe(10, bc, fp, dr);
    check("post_reset_busy_cycles", bc, 0);
    tick();
    pulse('0, 1);
    wait_quiet("redraw_all", 600);

    // Randomised batches of simultaneous requests.
    for (int b = 0; b < 25; b++) begin
      logic [NO-1:0] m;
      for (int i = 0; i < NO; i++) begin
        c_x[i] = $urandom_range(0, 170);
        c_y[i] = $urandom_range(0, 127);
        if (i >= 2) c_w[i] = $urandom_range(0, 7);
      end
      c_ecol = 3'($urandom_range(0, 7));
      apply_inputs();
      tick();
      m = NO'($urandom_range(1, (1 << NO) - 1));
      pulse(m, ($urandom_range(0, 7) == 0));
      wait_quiet("random", 3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/render_control.md
RENDER_CONTROL -- requirements
Module: render_control

Interface
REQ-001 Parameter NUM_ENEMY, 4, number of enemy slots serviced.
REQ-002 Parameter BG_COLOUR, 3'b000, colour used to erase.
REQ-003 Parameter PLAYER_COLOUR, 3'b010, player draw colour; BULLET_COLOUR, 3'b110, bullet draw colour.
REQ-004 clk  in  1  system clock.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 redraw_all  in  1  level-start strobe; marks every object pending.
REQ-007 player_move, bullet_move  in  1 each  single-cycle "position changed" pulses.
REQ-008 playerX/playerY, bulletX/bulletY  in  8/7 each  top-left pixel of the object.
REQ-009 enemy_move  in  NUM_ENEMY  per-enemy move pulses; enemyX  in  8*NUM_ENEMY; enemyY  in  7*NUM_ENEMY; enemy_width  in  3*NUM_ENEMY (0 = dead).
REQ-010 enemy_color  in  3  current enemy draw colour.
REQ-011 plot  out  1  pixel write enable to VGA adapter; vga_x out 8; vga_y out 7; colour out 3.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Objects: index 0 player (3x3), 1 bullet (1x1), 2..NUM_ENEMY+1 enemies (w x w, w = enemy_width).
REQ-014 Each object shall own a pending flag set by its move pulse or redraw_all; set shall win over a same-cycle clear.
REQ-015 Each object shall hold a last-drawn record (x, y, w); reset loads it from current inputs.
REQ-016 FSM states IDLE, ERASE, DRAW; IDLE -> ERASE when any pending, choosing the lowest pending index (fixed priority).
REQ-017 On IDLE->ERASE the chosen object's pending flag is cleared and its current x, y, w are snapshotted.
REQ-018 ERASE scans the last-drawn square row-major (x fastest), one pixel per cycle, colour BG_COLOUR; w=0 skips ERASE in zero cycles.
REQ-019 DRAW scans the snapshot square the same way with the object's colour; snapshot w=0 skips DRAW; at DRAW end, last-drawn := snapshot, state -> IDLE.
REQ-020 Pixels with x >= 160 or y >= 120 shall consume their cycle with plot=0.
REQ-021 plot, vga_x, vga_y, colour are registered; plot is 0 in IDLE and on skipped cycles.
REQ-022 Latency from idle: first erase pixel (plot=1) on the 3rd rising edge after the edge sampling the move pulse; square of width w costs exactly 2*w*w pixel cycles plus 1 IDLE cycle.
REQ-023 Move pulses arriving while busy for the same object re-set its pending flag; no pulse is lost, duplicates coalesce.
REQ-024 Scan counters are 3-bit; pixel address = base + offset computed at 9/8 bits before the off-screen check (no wrap to low coordinates).
REQ-025 enemy_color is sampled at snapshot time, not per pixel.

Reset
REQ-026 resetn=0 at any edge, including mid-scan: state IDLE, all pending 0, plot 0, vga_x 0, vga_y 0, colour 0, busy 0, counters 0.
REQ-027 Reset has priority over redraw_all and move pulses in the same cycle.

Structure
REQ-028 Shared package holds SCREEN_W=160, SCREEN_H=120, PLAYER_WIDTH=3, colour constants, and the FSM state enum.
REQ-029 One sub-module square_scanner (start, base x/y, width in; pixel x/y, valid, done out) used by both ERASE and DRAW.
REQ-030 Pending arbitration and last-drawn storage remain in render_control.

Verification
REQ-031 Idle, player_move with player at (80,115) previously drawn at (79,115) -> 9 black pixels at x79..81,y115..117 then 9 colour 010 pixels at x80..82; busy drops after 19 cycles.
REQ-032 player_move and enemy_move[0] in the same cycle -> player serviced fully first, enemy second; no interleaved pixels.
REQ-033 enemy 2 width 4 at (158,10) -> pixels with x 160,161 have plot=0; cycle count still 2*16.
REQ-034 enemy_width drops 3->0 then move pulse -> 9 black pixels, no draw pixels, last-drawn w=0; next pulse produces no plots.
REQ-035 bullet_move pulsed during bullet DRAW -> second erase/draw of bullet follows immediately.
REQ-036 resetn low mid-ERASE -> next cycle plot=0, busy=0, pending all 0; redraw_all afterwards redraws all objects in index order.
